mem_gather_ctrl: RTL and testbench

- Width-converting gather controller that sequences narrow memory beats into one wide word.
- It accepts IN_WIDTH-word beats on a valid/ready input and assembles RATIO = OUT_WIDTH/IN_WIDTH of them into an OUT_WIDTH-word buffer.
- It presents the full vector on a valid/ready output.
- It sits between the narrow memory read port and the wide compute-array operand bus; it supplies the sequencing and buffering that pure wiring cannot.

---
 rtl/mem_gather_ctrl_if.sv | 33 +++
 rtl/mem_gather_ctrl.sv | 85 ++++++++
 tb/tb_mem_gather_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_gather_ctrl_if.sv
// Narrow-beat input and wide-vector output streams of the gather controller.
// The controller uses the slave modport and its environment uses the master modport.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface mem_gather_ctrl_if #(
  parameter int DW        = `DATA_WIDTH,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 256
);
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int BW    = $clog2(RATIO) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [DW*IN_WIDTH-1:0]  in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW*OUT_WIDTH-1:0] out_data;
  logic [BW-1:0]           out_beats;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/mem_gather_ctrl.sv
// Gathers RATIO narrow beats (or fewer, ended by in_last) into one wide vector
// and holds it until the consumer takes it.
//
// state | meaning
// FILL  | accepting beats into the buffer at slice cnt
// DRAIN | vector presented on the output, input stalled
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_gather_ctrl #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 256
) (
  input logic              clk,
  input logic              rst,
  mem_gather_ctrl_if.slave bus
);
  localparam int DW    = `DATA_WIDTH;
  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BW    = $clog2(RATIO) + 1;
  localparam int SLICE = DW * IN_WIDTH;
  localparam int VW    = DW * OUT_WIDTH;

  if ((OUT_WIDTH % IN_WIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("mem_gather_ctrl: OUT_WIDTH/IN_WIDTH must be an integer power of two >= 2");
  end

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [VW-1:0]   vec_q,   vec_d;
  logic [BW-1:0]   beats_q, beats_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      vec_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    beats_d = beats_q;
    unique case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          vec_d[int'(cnt_q) * SLICE +: SLICE] = bus.in_data;
          if (cnt_q == CW'(RATIO - 1) || bus.in_last) begin
            beats_d = BW'(cnt_q) + BW'(1);
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Clearing here keeps short vectors zero-padded without a per-slice mask.
        if (bus.out_ready) begin
          vec_d   = '0;
          beats_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = vec_q;
  assign bus.out_beats = beats_q;
endmodule

// File: tb/tb_mem_gather_ctrl.sv
// Directed scenarios plus a randomly throttled run against a queue-based gather model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_mem_gather_ctrl;
  localparam int DW        = `DATA_WIDTH;
  localparam int IN_WIDTH  = 32;
  localparam int OUT_WIDTH = 256;
  localparam int RATIO     = OUT_WIDTH / IN_WIDTH;
  localparam int BW        = $clog2(RATIO) + 1;
  localparam int SLICE     = DW * IN_WIDTH;
  localparam int VW        = DW * OUT_WIDTH;
  localparam int NV        = 1000;
  localparam int BOUND     = 60000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  mem_gather_ctrl_if #(.DW(DW), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bif ();

  mem_gather_ctrl #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: beat k occupies slice k, everything above the last beat is zero.
  function automatic logic [VW-1:0] model_vec(input logic [SLICE-1:0] q[$]);
    logic [VW-1:0] v;
    v = '0;
    foreach (q[k]) v[k*SLICE +: SLICE] = q[k];
    return v;
  endfunction

  function automatic int diff_word(input logic [VW-1:0] a, input logic [VW-1:0] b);
    for (int w = 0; w < OUT_WIDTH; w++)
      if (a[w*DW +: DW] !== b[w*DW +: DW]) return w;
    return -1;
  endfunction

  function automatic logic [SLICE-1:0] fill(input int v);
    logic [DW-1:0] w;
    w = DW'(v);
    return {IN_WIDTH{w}};
  endfunction

  task automatic fill_beat(input logic [SLICE-1:0] d, input bit last);
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    bif.in_last  = last;
    step();
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_last   = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    n_total++; if (bif.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bif.in_ready); else n_pass++;
    n_total++; if (bif.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bif.out_valid); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(0)) $display("FAIL reset_out_beats: got %0d expected 0", bif.out_beats); else n_pass++;
    n_total++; if (bif.out_data !== '0) $display("FAIL reset_out_data: word %0d nonzero", diff_word(bif.out_data, '0)); else n_pass++;
  endtask

  task automatic test_full();
    logic [SLICE-1:0] q[$];
    logic [VW-1:0]    exp_v;
    bif.out_ready = 1'b1;
    for (int k = 0; k < RATIO; k++) begin
      q.push_back(fill(k + 1));
      n_total++; if (bif.in_ready !== 1'b1) $display("FAIL full_in_ready beat %0d: got %b expected 1", k, bif.in_ready); else n_pass++;
      fill_beat(fill(k + 1), 1'b0);
    end
    exp_v = model_vec(q);
    n_total++; if (bif.out_valid !== 1'b1) $display("FAIL full_out_valid: got %b expected 1", bif.out_valid); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(RATIO)) $display("FAIL full_out_beats: got %0d expected %0d", bif.out_beats, RATIO); else n_pass++;
    n_total++; if (bif.out_data !== exp_v) $display("FAIL full_out_data: word %0d got %0h expected %0h", diff_word(bif.out_data, exp_v), bif.out_data[diff_word(bif.out_data, exp_v)*DW +: DW], exp_v[diff_word(bif.out_data, exp_v)*DW +: DW]); else n_pass++;
    n_total++; if (bif.in_ready !== 1'b0) $display("FAIL full_drain_in_ready: got %b expected 0", bif.in_ready); else n_pass++;
    step();
    n_total++; if (bif.in_ready !== 1'b1) $display("FAIL full_refill_in_ready: got %b expected 1", bif.in_ready); else n_pass++;
    n_total++; if (bif.out_valid !== 1'b0) $display("FAIL full_after_out_valid: got %b expected 0", bif.out_valid); else n_pass++;
    bif.out_ready = 1'b0;
  endtask

  task automatic test_short();
    logic [SLICE-1:0] q[$];
    logic [VW-1:0]    exp_v;
    q = '{fill(8'hA1), fill(8'hA2), fill(8'hA3)};
    exp_v = model_vec(q);
    bif.out_ready = 1'b0;
    fill_beat(q[0], 1'b0);
    fill_beat(q[1], 1'b0);
    fill_beat(q[2], 1'b1);
    n_total++; if (bif.out_valid !== 1'b1) $display("FAIL short_out_valid: got %b expected 1", bif.out_valid); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(3)) $display("FAIL short_out_beats: got %0d expected 3", bif.out_beats); else n_pass++;
    n_total++; if (bif.out_data !== exp_v) $display("FAIL short_out_data: word %0d differs", diff_word(bif.out_data, exp_v)); else n_pass++;
    n_total++; if (bif.out_data[VW-1:3*SLICE] !== '0) $display("FAIL short_upper_zero: upper slices nonzero, word %0d", diff_word(bif.out_data, exp_v)); else n_pass++;
    bif.out_ready = 1'b1;
    step();
    bif.out_ready = 1'b0;
  endtask

  task automatic test_short_then_full();
    bif.out_ready = 1'b1;
    fill_beat(fill(8'h11), 1'b0);
    fill_beat(fill(8'h22), 1'b1);
    n_total++; if (bif.out_beats !== BW'(2)) $display("FAIL stf_short_beats: got %0d expected 2", bif.out_beats); else n_pass++;
    step();
    for (int k = 0; k < RATIO; k++) fill_beat(fill(8'hFF), 1'b0);
    n_total++; if (bif.out_data !== {VW{1'b1}}) $display("FAIL stf_full_data: word %0d not FF", diff_word(bif.out_data, {VW{1'b1}})); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(RATIO)) $display("FAIL stf_full_beats: got %0d expected %0d", bif.out_beats, RATIO); else n_pass++;
    step();
    bif.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [SLICE-1:0] q[$];
    logic [VW-1:0]    exp_v;
    bif.out_ready = 1'b0;
    for (int k = 0; k < RATIO; k++) begin
      q.push_back(fill(8'h30 + k));
      fill_beat(fill(8'h30 + k), 1'b0);
    end
    exp_v = model_vec(q);
    bif.in_valid = 1'b1;
    bif.in_data  = fill(8'h5C);
    bif.in_last  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_total++; if (bif.in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, bif.in_ready); else n_pass++;
      n_total++; if (bif.out_valid !== 1'b1) $display("FAIL bp_out_valid cycle %0d: got %b expected 1", c, bif.out_valid); else n_pass++;
      n_total++; if (bif.out_data !== exp_v) $display("FAIL bp_out_data cycle %0d: word %0d differs", c, diff_word(bif.out_data, exp_v)); else n_pass++;
      n_total++; if (bif.out_beats !== BW'(RATIO)) $display("FAIL bp_out_beats cycle %0d: got %0d expected %0d", c, bif.out_beats, RATIO); else n_pass++;
      step();
    end
    bif.out_ready = 1'b1;
    step();
    n_total++; if (bif.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", bif.in_ready); else n_pass++;
    step();
    bif.in_valid = 1'b0;
    q.delete();
    q.push_back(fill(8'h5C));
    for (int k = 1; k < RATIO; k++) begin
      q.push_back(fill(8'h60 + k));
      fill_beat(fill(8'h60 + k), 1'b0);
    end
    exp_v = model_vec(q);
    n_total++; if (bif.out_data !== exp_v) $display("FAIL bp_next_data: word %0d differs", diff_word(bif.out_data, exp_v)); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(RATIO)) $display("FAIL bp_next_beats: got %0d expected %0d", bif.out_beats, RATIO); else n_pass++;
    step();
    bif.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [SLICE-1:0] q[$];
    logic [VW-1:0]    exp_v;
    bif.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) fill_beat(fill(8'hE0 + k), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (bif.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", bif.in_ready); else n_pass++;
    n_total++; if (bif.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", bif.out_valid); else n_pass++;
    for (int k = 0; k < RATIO; k++) begin
      q.push_back(fill(8'hC0 + k));
      fill_beat(fill(8'hC0 + k), 1'b0);
    end
    exp_v = model_vec(q);
    n_total++; if (bif.out_data !== exp_v) $display("FAIL rstmid_clean_data: word %0d differs", diff_word(bif.out_data, exp_v)); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(RATIO)) $display("FAIL rstmid_clean_beats: got %0d expected %0d", bif.out_beats, RATIO); else n_pass++;
    // Reset together with an output handshake while draining.
    bif.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.out_ready = 1'b0;
    n_total++; if (bif.out_valid !== 1'b0) $display("FAIL rstdrain_out_valid: got %b expected 0", bif.out_valid); else n_pass++;
    n_total++; if (bif.in_ready !== 1'b1) $display("FAIL rstdrain_in_ready: got %b expected 1", bif.in_ready); else n_pass++;
    n_total++; if (bif.out_beats !== BW'(0)) $display("FAIL rstdrain_out_beats: got %0d expected 0", bif.out_beats); else n_pass++;
    n_total++; if (bif.out_data !== '0) $display("FAIL rstdrain_out_data: word %0d nonzero", diff_word(bif.out_data, '0)); else n_pass++;
  endtask

  task automatic test_random();
    logic [SLICE-1:0] beat_q[$];
    bit               last_q[$];
    logic [VW-1:0]    exp_q[$];
    int               nb_q[$];
    logic [SLICE-1:0] cur[$];
    logic [SLICE-1:0] b;
    int               n, bi, cyc, vi;
    bit               took;

    for (int v = 0; v < NV; v++) begin
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, RATIO)) : RATIO;
      cur.delete();
      for (int k = 0; k < n; k++) begin
        for (int w = 0; w < SLICE / 32; w++) b[w*32 +: 32] = $urandom;
        cur.push_back(b);
        beat_q.push_back(b);
        last_q.push_back((k == n - 1) && (n < RATIO || $urandom_range(0, 1) == 1));
      end
      exp_q.push_back(model_vec(cur));
      nb_q.push_back(n);
    end

    bi = 0; cyc = 0; vi = 0;
    bif.in_valid = 1'b0;
    while (exp_q.size() > 0 && cyc < BOUND) begin
      if (!bif.in_valid && bi < beat_q.size() && $urandom_range(0, 3) != 0) begin
        bif.in_valid = 1'b1;
        bif.in_data  = beat_q[bi];
        bif.in_last  = last_q[bi];
      end
      bif.out_ready = ($urandom_range(0, 9) < 7);
      if (bif.out_valid && bif.out_ready) begin
        n_total++; if (bif.out_data !== exp_q[0]) $display("FAIL rand_data vec %0d: word %0d differs", vi, diff_word(bif.out_data, exp_q[0])); else n_pass++;
        n_total++; if (bif.out_beats !== BW'(nb_q[0])) $display("FAIL rand_beats vec %0d: got %0d expected %0d", vi, bif.out_beats, nb_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        void'(nb_q.pop_front());
        vi++;
      end
      took = bif.in_valid && bif.in_ready;
      step();
      cyc++;
      if (took) begin
        bi++;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
      end
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    n_total++; if (exp_q.size() != 0) $display("FAIL rand_timeout: %0d vectors outstanding expected 0", exp_q.size()); else n_pass++;
    n_total++; if (bi != beat_q.size()) $display("FAIL rand_beats_consumed: got %0d expected %0d", bi, beat_q.size()); else n_pass++;
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.in_last   = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b0;
    test_reset();
    test_full();
    test_short();
    test_short_then_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
